interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 19 +
 rtl/prio_encoder.sv | 27 ++
 rtl/interrupt_controller.sv | 182 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared constants and types for the interrupt controller
package interrupt_controller_pkg;

    // Arbitration FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Register offsets from the block base address.
    localparam logic [15:0] IFG_OFS = 16'h0000;
    localparam logic [15:0] IE_OFS  = 16'h0002;

    // Fixed vector indices.
    localparam logic [5:0] NMI_VEC = 6'd62;
    localparam logic [5:0] RST_VEC = 6'd63;

endpackage

// File: rtl/prio_encoder.sv
// rtl/prio_encoder.sv - lowest-set-bit priority encoder
//
// Ports:
//   vec   - request vector, bit 0 has highest priority
//   valid - at least one bit of vec is set
//   idx   - index of the lowest set bit (0 when valid is low)
module prio_encoder #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |vec;
        idx   = '0;
        // Scan from the top down so the lowest set bit is the last to win.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-triggered interrupt controller with NMI and vector output
//
// Ports:
//   MCLK        - system clock, all state on its rising edge
//   rst         - synchronous active-low reset
//   MAB         - CPU address bus; IFG at BASE_ADDR, IE at BASE_ADDR+2
//   MDBwrite    - CPU write data, low byte written to the addressed register
//   MW          - write strobe
//   BW          - byte/word access flag (both write the low byte)
//   MDBread     - combinational register read data, zero when not addressed
//   IRQ         - peripheral request lines, bit 0 highest priority
//   NMIsrc      - non-maskable request line
//   NMI / INT   - requests to the CPU, held until INTACK
//   IntAddrLSBs - presented vector index
//   INTACK      - one-cycle acknowledge of the presented vector
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0100,
    parameter int          VEC_TOP   = 50
) (
    input  logic               MCLK,
    input  logic               rst,
    input  logic [15:0]        MAB,
    input  logic [15:0]        MDBwrite,
    input  logic               MW,
    input  logic               BW,
    output logic [15:0]        MDBread,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               NMIsrc,
    output logic               NMI,
    output logic               INT,
    output logic [5:0]         IntAddrLSBs,
    input  logic               INTACK
);

    localparam int          IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [15:0] IFG_ADDR = BASE_ADDR + IFG_OFS;
    localparam logic [15:0] IE_ADDR  = BASE_ADDR + IE_OFS;

    logic [NUM_SRC-1:0] irq_d;
    logic [NUM_SRC-1:0] ifg;
    logic [NUM_SRC-1:0] ie;
    logic [NUM_SRC-1:0] ifg_n;
    logic [NUM_SRC-1:0] ie_n;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] pend;
    logic               nmi_d;
    logic               nmi_pend;
    logic               nmi_pend_n;
    logic               nmi_rise;

    state_t             state;
    state_t             state_n;
    logic               grant_nmi;
    logic               grant_nmi_n;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      grant_idx_n;
    logic [5:0]         vec;
    logic [5:0]         vec_n;

    logic               sel_ifg;
    logic               sel_ie;
    logic               ack;
    logic               pend_valid;
    logic [IW-1:0]      pend_idx;
    logic               unused_bits;

    // Byte/word size and the upper data byte do not affect these 8-bit registers.
    assign unused_bits = ^{BW, MDBwrite[15:NUM_SRC]};

    assign sel_ifg  = (MAB == IFG_ADDR);
    assign sel_ie   = (MAB == IE_ADDR);
    assign irq_rise = IRQ & ~irq_d;
    assign nmi_rise = NMIsrc & ~nmi_d;
    assign pend     = ifg & ie;
    assign ack      = (state == ST_GRANT) && INTACK;

    prio_encoder #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio (
        .vec   (pend),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    // Flag update: software write first, then acknowledge clear, then hardware
    // set on top so a fresh edge is never lost to a same-cycle clear.
    always_comb begin
        ifg_n      = ifg;
        ie_n       = ie;
        nmi_pend_n = nmi_pend;
        if (MW && sel_ifg) begin
            ifg_n = MDBwrite[NUM_SRC-1:0];
        end
        if (MW && sel_ie) begin
            ie_n = MDBwrite[NUM_SRC-1:0];
        end
        if (ack && !grant_nmi) begin
            ifg_n[grant_idx] = 1'b0;
        end
        if (ack && grant_nmi) begin
            nmi_pend_n = 1'b0;
        end
        ifg_n      = ifg_n | irq_rise;
        nmi_pend_n = nmi_pend_n | nmi_rise;
    end

    // Arbitration. GAP arbitrates like IDLE so that a request already waiting
    // is presented right after the single low cycle; with nothing pending it
    // falls back to IDLE. GRANT is frozen until the acknowledge.
    always_comb begin
        state_n     = state;
        grant_nmi_n = grant_nmi;
        grant_idx_n = grant_idx;
        vec_n       = vec;
        case (state)
            ST_IDLE, ST_GAP: begin
                state_n = ST_IDLE;
                if (nmi_pend) begin
                    state_n     = ST_GRANT;
                    grant_nmi_n = 1'b1;
                    vec_n       = NMI_VEC;
                end else if (pend_valid) begin
                    state_n     = ST_GRANT;
                    grant_nmi_n = 1'b0;
                    grant_idx_n = pend_idx;
                    vec_n       = 6'(VEC_TOP - int'(pend_idx));
                end
            end
            ST_GRANT: begin
                if (INTACK) begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!rst) begin
            irq_d     <= '0;
            nmi_d     <= 1'b0;
            ifg       <= '0;
            ie        <= '0;
            nmi_pend  <= 1'b0;
            state     <= ST_IDLE;
            grant_nmi <= 1'b0;
            grant_idx <= '0;
            vec       <= RST_VEC;
        end else begin
            irq_d     <= IRQ;
            nmi_d     <= NMIsrc;
            ifg       <= ifg_n;
            ie        <= ie_n;
            nmi_pend  <= nmi_pend_n;
            state     <= state_n;
            grant_nmi <= grant_nmi_n;
            grant_idx <= grant_idx_n;
            vec       <= vec_n;
        end
    end

    // Requests are gated by rst so they drop in the same cycle reset is applied.
    assign INT         = rst && (state == ST_GRANT) && !grant_nmi;
    assign NMI         = rst && (state == ST_GRANT) && grant_nmi;
    assign IntAddrLSBs = rst ? vec : RST_VEC;

    always_comb begin
        MDBread = 16'h0000;
        if (sel_ifg) begin
            MDBread = 16'(ifg);
        end else if (sel_ie) begin
            MDBread = 16'(ie);
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    localparam logic [15:0] BASE = 16'h0100;
    localparam int          VTOP = 50;

    logic        MCLK = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] MAB = 16'h0000;
    logic [15:0] MDBwrite = 16'h0000;
    logic        MW = 1'b0;
    logic        BW = 1'b0;
    logic [15:0] MDBread;
    logic [7:0]  IRQ = 8'h00;
    logic        NMIsrc = 1'b0;
    logic        NMI;
    logic        INT;
    logic [5:0]  IntAddrLSBs;
    logic        INTACK = 1'b0;

    int tests = 0;
    int fails = 0;

    interrupt_controller #(
        .NUM_SRC   (8),
        .BASE_ADDR (BASE),
        .VEC_TOP   (VTOP)
    ) dut (
        .MCLK        (MCLK),
        .rst         (rst),
        .MAB         (MAB),
        .MDBwrite    (MDBwrite),
        .MW          (MW),
        .BW          (BW),
        .MDBread     (MDBread),
        .IRQ         (IRQ),
        .NMIsrc      (NMIsrc),
        .NMI         (NMI),
        .INT         (INT),
        .IntAddrLSBs (IntAddrLSBs),
        .INTACK      (INTACK)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [7:0] ie;
        logic [7:0] irq;
        logic       exp_int;
        logic [5:0] exp_vec;
    } vec_rec_t;

    vec_rec_t tbl[12];

    // Reference model state: flags as plain integers, grant as a source number
    // (-1 for NMI, -2 for none).
    int m_ifg, m_ie, m_prev_irq, m_grant, m_vec;
    bit m_nmi, m_prev_nmi;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic bw);
        MAB = addr; MDBwrite = data; BW = bw; MW = 1'b1;
        tick();
        MW = 1'b0; BW = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr, input int exp);
        MAB = addr;
        #1;
        check(name, int'(MDBread), exp);
    endtask

    task automatic ack();
        INTACK = 1'b1;
        tick();
        INTACK = 1'b0;
    endtask

    task automatic do_reset(input bit verify);
        rst = 1'b0; IRQ = 8'h00; NMIsrc = 1'b0; MW = 1'b0; INTACK = 1'b0;
        repeat (3) tick();
        if (verify) begin
            check("rst_int", int'(INT), 0);
            check("rst_nmi", int'(NMI), 0);
            check("rst_vec", int'(IntAddrLSBs), 63);
            rd_check("rst_ifg", BASE, 0);
            rd_check("rst_ie", BASE + 16'd2, 0);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic cleanup();
        wr(BASE + 16'd2, 16'h0000, 1'b0);
        wr(BASE, 16'h0000, 1'b0);
        if (INT || NMI) ack();
        tick();
        tick();
    endtask

    function automatic int lowest(input int v);
        for (int k = 0; k < 8; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Advance the model across one clock edge given the inputs presented before it.
    task automatic model_edge(input int irq, input bit nsrc, input bit mw,
                              input logic [15:0] addr, input int wdata, input bit iack);
        int new_ifg, new_ie;
        bit new_nmi;
        new_ifg = m_ifg; new_ie = m_ie; new_nmi = m_nmi;
        if (mw && addr == BASE)          new_ifg = wdata & 8'hFF;
        if (mw && addr == BASE + 16'd2)  new_ie  = wdata & 8'hFF;
        if (m_grant != -2) begin
            if (iack) begin
                if (m_grant == -1) new_nmi = 1'b0;
                else new_ifg = new_ifg & ~(1 << m_grant);
                m_grant = -2;
            end
        end else if (m_nmi) begin
            m_grant = -1; m_vec = 62;
        end else if ((m_ifg & m_ie) != 0) begin
            m_grant = lowest(m_ifg & m_ie);
            m_vec = VTOP - m_grant;
        end
        new_ifg = new_ifg | (irq & ~m_prev_irq & 8'hFF);
        new_nmi = new_nmi | (nsrc & ~m_prev_nmi);
        m_ifg = new_ifg; m_ie = new_ie; m_nmi = new_nmi;
        m_prev_irq = irq; m_prev_nmi = nsrc;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            tbl[k] = '{ie: 8'(1 << k), irq: 8'(1 << k), exp_int: 1'b1, exp_vec: 6'(VTOP - k)};
        end
        tbl[8]  = '{ie: 8'hFF, irq: 8'h0A, exp_int: 1'b1, exp_vec: 6'd49};
        tbl[9]  = '{ie: 8'h00, irq: 8'h10, exp_int: 1'b0, exp_vec: 6'd0};
        tbl[10] = '{ie: 8'hF0, irq: 8'h0F, exp_int: 1'b0, exp_vec: 6'd0};
        tbl[11] = '{ie: 8'h0C, irq: 8'hFF, exp_int: 1'b1, exp_vec: 6'd48};

        do_reset(1'b1);

        // Single source latency and ack.
        wr(BASE + 16'd2, 16'h0020, 1'b0);
        IRQ = 8'h20;
        tick();
        IRQ = 8'h00;
        check("lat1_int", int'(INT), 0);
        tick();
        check("lat2_int", int'(INT), 1);
        check("lat2_vec", int'(IntAddrLSBs), 45);
        rd_check("single_ifg", BASE, 16'h0020);
        ack();
        check("gap_int", int'(INT), 0);
        rd_check("acked_ifg", BASE, 0);
        tick();
        check("idle_int", int'(INT), 0);

        // Table of masks and request patterns.
        for (int i = 0; i < 12; i++) begin
            wr(BASE + 16'd2, 16'(tbl[i].ie), 1'b0);
            IRQ = tbl[i].irq;
            tick();
            IRQ = 8'h00;
            tick();
            check($sformatf("tbl%0d_int", i), int'(INT), int'(tbl[i].exp_int));
            check($sformatf("tbl%0d_nmi", i), int'(NMI), 0);
            if (tbl[i].exp_int) check($sformatf("tbl%0d_vec", i), int'(IntAddrLSBs), int'(tbl[i].exp_vec));
            cleanup();
        end

        // Priority and freeze during GRANT.
        wr(BASE + 16'd2, 16'h00FF, 1'b0);
        IRQ = 8'h0A; tick(); IRQ = 8'h00; tick();
        check("prio_vec1", int'(IntAddrLSBs), 49);
        IRQ = 8'h01; tick(); IRQ = 8'h00; tick();
        check("freeze_vec", int'(IntAddrLSBs), 49);
        check("freeze_int", int'(INT), 1);
        ack();
        check("prio_gap", int'(INT), 0);
        tick();
        check("prio_int2", int'(INT), 1);
        check("prio_vec2", int'(IntAddrLSBs), 50);
        ack(); tick();
        check("prio_vec3", int'(IntAddrLSBs), 47);
        check("prio_int3", int'(INT), 1);
        cleanup();

        // NMI precedence.
        wr(BASE + 16'd2, 16'h0001, 1'b0);
        IRQ = 8'h01; NMIsrc = 1'b1; tick(); IRQ = 8'h00; NMIsrc = 1'b0; tick();
        check("nmi_nmi", int'(NMI), 1);
        check("nmi_int", int'(INT), 0);
        check("nmi_vec", int'(IntAddrLSBs), 62);
        ack();
        check("nmi_gap", int'(NMI | INT), 0);
        tick();
        check("nmi_next_int", int'(INT), 1);
        check("nmi_next_vec", int'(IntAddrLSBs), 50);
        cleanup();

        // Hardware set wins over a software clear and over an acknowledge clear.
        MAB = BASE; MDBwrite = 16'h0000; MW = 1'b1; IRQ = 8'h04;
        tick();
        MW = 1'b0; IRQ = 8'h00;
        rd_check("coll_sw_ifg", BASE, 16'h0004);
        wr(BASE + 16'd2, 16'h0004, 1'b0);
        tick();
        check("coll_grant_vec", int'(IntAddrLSBs), 48);
        INTACK = 1'b1; IRQ = 8'h04; tick(); INTACK = 1'b0; IRQ = 8'h00;
        rd_check("coll_ack_ifg", BASE, 16'h0004);
        check("coll_gap_int", int'(INT), 0);
        tick();
        check("coll_regrant", int'(INT), 1);
        cleanup();

        // Masking and bus decode.
        IRQ = 8'h10; tick(); IRQ = 8'h00; tick(); tick();
        check("mask_int", int'(INT), 0);
        rd_check("mask_ifg", BASE, 16'h0010);
        wr(BASE + 16'd2, 16'hAB10, 1'b1);
        tick();
        check("bw_int", int'(INT), 1);
        check("bw_vec", int'(IntAddrLSBs), 46);
        rd_check("bw_ie", BASE + 16'd2, 16'h0010);
        wr(BASE + 16'd4, 16'h00FF, 1'b0);
        rd_check("unmapped", BASE + 16'd4, 0);
        rd_check("unmapped_ie", BASE + 16'd2, 16'h0010);

        // Software clear during GRANT keeps the grant; reset abandons it.
        wr(BASE + 16'd2, 16'h0000, 1'b0);
        wr(BASE, 16'h0000, 1'b0);
        check("swclr_hold_int", int'(INT), 1);
        check("swclr_hold_vec", int'(IntAddrLSBs), 46);
        rst = 1'b0; INTACK = 1'b1; tick(); INTACK = 1'b0;
        check("rstg_int", int'(INT), 0);
        check("rstg_vec", int'(IntAddrLSBs), 63);
        rst = 1'b1; tick();
        check("rstg_after_int", int'(INT), 0);

        // Randomized run against the reference model.
        do_reset(1'b0);
        m_ifg = 0; m_ie = 0; m_prev_irq = 0; m_grant = -2; m_vec = 63;
        m_nmi = 1'b0; m_prev_nmi = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [15:0] a;
            int          r;
            if ($urandom_range(0, 3) == 0) IRQ = IRQ ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) NMIsrc = ~NMIsrc;
            r = $urandom_range(0, 7);
            a = (r == 0) ? BASE : (r == 1) ? BASE + 16'd2 : (r == 2) ? BASE + 16'd4 : BASE;
            MW = (r <= 2);
            MAB = a;
            MDBwrite = 16'($urandom);
            BW = 1'($urandom);
            INTACK = ($urandom_range(0, 2) == 0);
            model_edge(int'(IRQ), NMIsrc, MW, a, int'(MDBwrite), INTACK);
            tick();
            MW = 1'b0; INTACK = 1'b0;
            check($sformatf("rnd%0d_int", c), int'(INT), (m_grant >= 0) ? 1 : 0);
            check($sformatf("rnd%0d_nmi", c), int'(NMI), (m_grant == -1) ? 1 : 0);
            if (m_grant != -2) check($sformatf("rnd%0d_vec", c), int'(IntAddrLSBs), m_vec);
            rd_check($sformatf("rnd%0d_ifg", c), BASE, m_ifg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
